duty_clock_gen: RTL

DUTY_CLOCK_GEN -- requirements
Module: duty_clock_gen

---
 rtl/duty_clock_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/duty_clock_gen.sv
// Programmable-duty clock generator: period and high count are reloaded only
// at period boundaries so every generated period is internally consistent.
module duty_clock_gen #(
    parameter int W          = 8,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_HIGH   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cfg_load,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_high,
    output logic         clk_out,
    output logic         period_tick,
    output logic [W-1:0] phase,
    output logic         cfg_pending
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] phase_nxt;
    logic [W-1:0] p_act, p_act_nxt, h_act, h_act_nxt;
    logic [W-1:0] pend_p, pend_h, pend_p_nxt, pend_h_nxt;
    logic         clk_out_nxt, tick_nxt, pend_nxt;
    logic         wrap, apply;

    function automatic logic [W-1:0] clamp_period(input logic [W-1:0] p);
        return (p < W'(2)) ? W'(2) : p;
    endfunction

    // Config may only switch at a wrap or while idle, never mid-period.
    assign wrap  = (state == RUN) && en && (phase == p_act - W'(1));
    assign apply = (state == IDLE) || wrap;

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        clk_out_nxt = clk_out;
        tick_nxt    = period_tick;
        p_act_nxt   = p_act;
        h_act_nxt   = h_act;
        pend_nxt    = cfg_pending;
        pend_p_nxt  = pend_p;
        pend_h_nxt  = pend_h;

        if (apply && cfg_pending) begin
            p_act_nxt = clamp_period(pend_p);
            h_act_nxt = pend_h;
            pend_nxt  = 1'b0;
        end
        // A load on an apply edge stays pending for the following boundary.
        if (cfg_load) begin
            pend_p_nxt = cfg_period;
            pend_h_nxt = cfg_high;
            pend_nxt   = 1'b1;
        end

        case (state)
            IDLE: begin
                phase_nxt   = '0;
                clk_out_nxt = 1'b0;
                tick_nxt    = 1'b0;
                if (en) begin
                    state_nxt   = RUN;
                    clk_out_nxt = (h_act_nxt != '0);
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt   = IDLE;
                    phase_nxt   = '0;
                    clk_out_nxt = 1'b0;
                    tick_nxt    = 1'b0;
                end else begin
                    phase_nxt   = wrap ? '0 : phase + W'(1);
                    clk_out_nxt = (phase_nxt < h_act_nxt);
                    tick_nxt    = (phase_nxt == p_act_nxt - W'(1));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= '0;
            clk_out     <= 1'b0;
            period_tick <= 1'b0;
            cfg_pending <= 1'b0;
            p_act       <= clamp_period(W'(DEF_PERIOD));
            h_act       <= W'(DEF_HIGH);
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            clk_out     <= clk_out_nxt;
            period_tick <= tick_nxt;
            cfg_pending <= pend_nxt;
            p_act       <= p_act_nxt;
            h_act       <= h_act_nxt;
        end
    end

    // Pending payload is only meaningful while cfg_pending is set.
    always_ff @(posedge clk) begin
        pend_p <= pend_p_nxt;
        pend_h <= pend_h_nxt;
    end

endmodule
